// File: rtl/sync_fifo_pkg.sv
// Shared defaults for the show-ahead synchronous FIFO.
// Real widths come down from the core configuration.
package sync_fifo_pkg;

    localparam int DEF_XLEN       = 32;
    localparam int DEF_ADDR_WIDTH = 5;

endpackage

// File: rtl/sync_fifo_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register holds its value while re is low.
module DualPortRam
    import sync_fifo_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wAddr,
    input  logic [XLEN-1:0]       wData,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] rAddr,
    output logic [XLEN-1:0]       q
);

    logic [XLEN-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wAddr] <= wData;
        end
        if (re) begin
            q <= mem[rAddr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO over a registered-read RAM.
// RAM read register acts as a prefetch slot feeding the output stage.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [XLEN-1:0]       i_wr_data,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [XLEN-1:0]       o_rd_data,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] wrPtr;
    logic [ADDR_WIDTH:0] rdPtr;
    logic [ADDR_WIDTH:0] count;
    logic                acceptReady;
    logic                qValid;
    logic                outValid;
    logic [XLEN-1:0]     outData;
    logic [XLEN-1:0]     ramQ;
    logic                full;
    logic                wrFire;
    logic                rdFire;
    logic                committed;
    logic                outLoad;
    logic                ramRe;

    assign full       = (count == DEPTH);
    assign o_wr_ready = acceptReady && !full;
    assign wrFire     = i_wr_valid && o_wr_ready;
    assign rdFire     = outValid && i_rd_ready;

    // Registered pointers: only words written on an earlier edge are readable,
    // which also keeps read and write addresses apart on every edge.
    assign committed  = (wrPtr != rdPtr);
    assign outLoad    = qValid && (!outValid || rdFire);
    assign ramRe      = committed && (!qValid || outLoad);

    DualPortRam #(
        .XLEN       (XLEN),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) uRam (
        .clk   (i_clk),
        .we    (wrFire),
        .wAddr (wrPtr[ADDR_WIDTH-1:0]),
        .wData (i_wr_data),
        .re    (ramRe),
        .rAddr (rdPtr[ADDR_WIDTH-1:0]),
        .q     (ramQ)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            acceptReady <= 1'b0;
            wrPtr       <= '0;
            rdPtr       <= '0;
            qValid      <= 1'b0;
            outValid    <= 1'b0;
            outData     <= '0;
        end else begin
            acceptReady <= 1'b1;
            if (wrFire) begin
                wrPtr <= wrPtr + ONE;
            end
            if (ramRe) begin
                rdPtr <= rdPtr + ONE;
            end
            qValid <= ramRe || (qValid && !outLoad);
            if (outLoad) begin
                outValid <= 1'b1;
                outData  <= ramQ;
            end else if (rdFire) begin
                outValid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            count <= '0;
        end else begin
            unique case (1'b1)
                (wrFire && !rdFire): count <= count + ONE;
                (rdFire && !wrFire): count <= count - ONE;
                default:             count <= count;
            endcase
        end
    end

    assign o_rd_valid = outValid;
    assign o_rd_data  = outData;
    assign o_count    = count;
    assign o_full     = full;
    assign o_empty    = (count == '0);

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter XLEN, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, log2 of capacity; capacity = 2^ADDR_WIDTH words.
REQ-003 SHALL have port i_clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port i_rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_wr_valid  input  1  producer offers i_wr_data.
REQ-006 SHALL have port o_wr_ready  output  1  FIFO can accept a word this cycle.
REQ-007 SHALL have port i_wr_data  input  XLEN  write data.
REQ-008 SHALL have port o_rd_valid  output  1  o_rd_data holds the oldest word.
REQ-009 SHALL have port i_rd_ready  input  1  consumer takes o_rd_data this cycle.
REQ-010 SHALL have port o_rd_data  output  XLEN  oldest word, show-ahead.
REQ-011 SHALL have port o_count  output  ADDR_WIDTH+1  words held, including output stage.
REQ-012 SHALL have ports o_full, o_empty  output  1 each  o_count == 2^ADDR_WIDTH / o_count == 0.

Function
REQ-013 Write handshake: word accepted on an edge where i_wr_valid && o_wr_ready; o_wr_ready SHALL equal !o_full.
REQ-014 Read handshake: word consumed on an edge where o_rd_valid && i_rd_ready; o_rd_data SHALL stay stable while o_rd_valid && !i_rd_ready.
REQ-015 Storage SHALL be a DualPortRam with 1-cycle registered read; accepted word written at wr_ptr[ADDR_WIDTH-1:0].
REQ-016 Pointers wr_ptr, rd_ptr SHALL be ADDR_WIDTH+1 bits, increment by 1, wrap modulo 2^(ADDR_WIDTH+1); RAM address = low ADDR_WIDTH bits.
REQ-017 Prefetch: SHALL issue a RAM read of rd_ptr when the RAM holds a committed word (written on a prior edge) and the output stage is empty, or is being consumed this cycle, and no prefetch is in flight to it.
REQ-018 Output stage SHALL load RAM o_q one cycle after the prefetch; o_rd_valid rises the same edge.
REQ-019 Latency: word accepted into an empty FIFO on edge N SHALL appear with o_rd_valid=1 after edge N+2; no combinational write-to-read bypass.
REQ-020 Back-to-back: with continuous i_rd_ready and ≥2 words stored, throughput SHALL be one word per cycle with no bubbles.
REQ-021 o_count SHALL increment on accept-only, decrement on consume-only, hold when both or neither occur.
REQ-022 Full: i_wr_valid while o_full SHALL be ignored (no write, pointers unchanged), even if a read occurs the same edge.
REQ-023 Empty: o_rd_valid=0; i_rd_ready ignored; o_rd_data value undefined but SHALL not change count.
REQ-024 RAM read and write SHALL never target the same address on the same edge.
REQ-025 FIFO order SHALL be strict: words read out exactly in acceptance order, across pointer wrap.

Reset
REQ-026 While i_rstn=0: wr_ptr=rd_ptr=0, o_count=0, o_empty=1, o_full=0, o_wr_ready=0 during reset then 1 on first edge after release, o_rd_valid=0, in-flight prefetch cancelled.
REQ-027 Reset asserted mid-operation SHALL discard all contents; RAM contents need not be cleared.
REQ-028 o_rd_data SHALL reset to 0.

Structure
REQ-029 No shared package typedefs required; XLEN/ADDR_WIDTH passed as parameters from the top-level core config.
REQ-030 SHALL instantiate exactly one DualPortRam sub-module (XLEN, ADDR_WIDTH passed through); pointer/prefetch/output-stage logic in sync_fifo, target 150-250 lines.

Verification
REQ-031 Reset then write 32'hdeadbeef, 32'h8badf00d with i_rd_ready=1 -> o_rd_valid first high 2 edges after first accept; reads deadbeef then 8badf00d; o_count returns to 0.
REQ-032 Write 32 words 0..31, i_rd_ready=0 -> o_full=1, o_count=32, o_wr_ready=0; 33rd write 32'hcafebabe ignored; drain reads 0..31 exactly.
REQ-033 Simultaneous read and write at count=5 for 10 cycles -> o_count stays 5, output order preserved.
REQ-034 Stream 100 incrementing words with continuous valid/ready -> no bubbles after fill, pointers wrap, data 0..99 in order.
REQ-035 Random i_rd_ready stall with o_rd_valid=1 -> o_rd_data held unchanged across stall cycles.
REQ-036 Assert i_rstn=0 with count=7 mid-stream -> immediately o_empty=1, o_rd_valid=0, o_count=0; after release, new word 32'hdefac8ed is first read out.
